// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer.
// Walks header / data phases and drives register clock enables.
module spi_fsm #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             sclk_pos,
    input  logic             rw_bit,
    output logic             addr_we,
    output logic             sr_we,
    output logic             dm_we,
    output logic             miso_buff,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_GET          = 3'd1;
    localparam logic [2:0] S_GOT          = 3'd2;
    localparam logic [2:0] S_READ_LOAD    = 3'd3;
    localparam logic [2:0] S_READ_SEND    = 3'd4;
    localparam logic [2:0] S_WRITE_GET    = 3'd5;
    localparam logic [2:0] S_WRITE_COMMIT = 3'd6;
    localparam logic [2:0] S_DONE         = 3'd7;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_edge;

    // Final serial edge of the current WIDTH-bit phase.
    assign last_edge = sclk_pos && (cnt_q == LAST);

    // State and bit counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; chip-select release beats any simultaneous edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q != S_IDLE && cs_n) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!cs_n) begin
                        state_d = S_GET;
                        cnt_d   = '0;
                    end
                end
                S_GET: begin
                    if (last_edge) begin
                        state_d = S_GOT;
                        cnt_d   = '0;
                    end else if (sclk_pos) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GOT: begin
                    state_d = rw_bit ? S_READ_LOAD : S_WRITE_GET;
                end
                S_READ_LOAD: begin
                    state_d = S_READ_SEND;
                end
                S_READ_SEND: begin
                    if (last_edge) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else if (sclk_pos) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WRITE_GET: begin
                    if (last_edge) begin
                        state_d = S_WRITE_COMMIT;
                        cnt_d   = '0;
                    end else if (sclk_pos) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WRITE_COMMIT: begin
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Moore strobe decode of the registered state.
    always_comb begin
        addr_we   = 1'b0;
        sr_we     = 1'b0;
        dm_we     = 1'b0;
        miso_buff = 1'b0;
        case (state_q)
            S_GOT:          addr_we   = 1'b1;
            S_READ_LOAD:    sr_we     = 1'b1;
            S_READ_SEND:    miso_buff = 1'b1;
            S_WRITE_COMMIT: dm_we     = 1'b1;
            default:        ;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign state   = state_q;
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm.
// Edge-count model plus directed literal checks.
module tb_spi_fsm;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cs_n;
    logic             sclk_pos;
    logic             rw_bit;
    logic             addr_we;
    logic             sr_we;
    logic             dm_we;
    logic             miso_buff;
    logic             busy;
    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;

    spi_fsm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .sclk_pos  (sclk_pos),
        .rw_bit    (rw_bit),
        .addr_we   (addr_we),
        .sr_we     (sr_we),
        .dm_we     (dm_we),
        .miso_buff (miso_buff),
        .busy      (busy),
        .state     (state),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a transaction is described by edges seen in the header,
    // edges seen in the data phase and cycles elapsed after each phase.
    int m_act  = 0;
    int m_hdr  = 0;
    int m_data = 0;
    int m_t    = 0;
    int m_td   = 0;
    bit m_rw   = 1'b0;

    function automatic int m_state();
        if (m_act == 0) return 0;
        if (m_hdr < WIDTH) return 1;
        if (m_t == 0) return 2;
        if (m_rw) begin
            if (m_t == 1) return 3;
            if (m_data < WIDTH) return 4;
            return 7;
        end
        if (m_data < WIDTH) return 5;
        if (m_td == 0) return 6;
        return 7;
    endfunction

    function automatic int m_cnt();
        int s;
        s = m_state();
        if (s == 1) return m_hdr;
        if (s == 4 || s == 5) return m_data;
        return 0;
    endfunction

    always @(posedge clk) begin
        int cur;
        cur = m_state();
        if (reset) begin
            m_act = 0;
        end else if (cur == 0) begin
            if (!cs_n) begin
                m_act  = 1;
                m_hdr  = 0;
                m_data = 0;
                m_t    = 0;
                m_td   = 0;
            end
        end else if (cs_n) begin
            m_act = 0;
        end else begin
            case (cur)
                1: if (sclk_pos) m_hdr++;
                2: begin m_rw = rw_bit; m_t++; end
                3: m_t++;
                4, 5: if (sclk_pos) m_data++;
                6: m_td++;
                default: ;
            endcase
        end
    end

    bit         chk_on   = 1'b0;
    bit         trace_on = 1'b0;
    int         n_addr, n_sr, n_dm, n_miso;
    logic [2:0] seq[$];

    // Per-cycle compare against the model, plus strobe tallies.
    always @(negedge clk) begin
        logic [11:0] exp_v, act_v;
        int s;
        if (chk_on) begin
            s = m_state();
            exp_v = {3'(s), 4'(m_cnt()),
                     s == 2, s == 3, s == 6, s == 4, s != 0};
            act_v = {state, bit_cnt, addr_we, sr_we, dm_we, miso_buff, busy};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model t=%0t got=%03h want=%03h",
                         $time, act_v, exp_v);
            end
        end
        if (trace_on) begin
            if (addr_we)   n_addr++;
            if (sr_we)     n_sr++;
            if (dm_we)     n_dm++;
            if (miso_buff) n_miso++;
            if (seq.size() == 0 || seq[$] !== state) seq.push_back(state);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        sclk_pos = 1'b1;
        step(1);
        sclk_pos = 1'b0;
        step(2);
    endtask

    task automatic clear_trace();
        n_addr = 0;
        n_sr   = 0;
        n_dm   = 0;
        n_miso = 0;
        seq.delete();
    endtask

    // Full write up to DONE, leaving cs_n low.
    task automatic write_body();
        rw_bit = 1'b0;
        cs_n   = 1'b0;
        step(1);
        chk("get_lat", 32'(state), 1);
        repeat (WIDTH - 1) pulse();
        sclk_pos = 1'b1;
        step(1);
        sclk_pos = 1'b0;
        chk("w_addr_we", 32'(addr_we), 1);
        chk("w_got", 32'(state), 2);
        step(1);
        chk("w_addr_off", 32'(addr_we), 0);
        chk("w_wget", 32'(state), 5);
        repeat (WIDTH - 1) pulse();
        sclk_pos = 1'b1;
        step(1);
        sclk_pos = 1'b0;
        chk("w_dm_we", 32'(dm_we), 1);
        step(1);
        chk("w_dm_off", 32'(dm_we), 0);
        chk("w_done", 32'(state), 7);
    endtask

    int w_seq[7] = '{0, 1, 2, 5, 6, 7, 0};

    initial begin
        reset    = 1'b1;
        cs_n     = 1'b1;
        sclk_pos = 1'b0;
        rw_bit   = 1'b0;
        step(1);
        chk_on = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt", 32'(bit_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        step(1);

        // Write transaction
        clear_trace();
        trace_on = 1'b1;
        write_body();
        cs_n = 1'b1;
        step(1);
        chk("w_idle", 32'(state), 0);
        step(1);
        trace_on = 1'b0;
        chk("w_n_addr", n_addr, 1);
        chk("w_n_dm", n_dm, 1);
        chk("w_n_sr", n_sr, 0);
        chk("w_n_miso", n_miso, 0);
        chk("w_seq_len", seq.size(), 7);
        for (int i = 0; i < 7; i++)
            chk("w_seq", (i < seq.size()) ? 32'(seq[i]) : -1, w_seq[i]);

        // Read transaction
        clear_trace();
        trace_on = 1'b1;
        rw_bit = 1'b1;
        cs_n   = 1'b0;
        step(1);
        repeat (WIDTH - 1) pulse();
        sclk_pos = 1'b1;
        step(1);
        sclk_pos = 1'b0;
        chk("r_addr_we", 32'(addr_we), 1);
        step(1);
        chk("r_sr_we", 32'(sr_we), 1);
        chk("r_addr_off", 32'(addr_we), 0);
        step(1);
        chk("r_miso", 32'(miso_buff), 1);
        chk("r_send", 32'(state), 4);
        repeat (WIDTH - 1) pulse();
        sclk_pos = 1'b1;
        step(1);
        sclk_pos = 1'b0;
        chk("r_done", 32'(state), 7);
        chk("r_miso_off", 32'(miso_buff), 0);
        cs_n = 1'b1;
        step(2);
        trace_on = 1'b0;
        chk("r_n_miso", n_miso, 3 * (WIDTH - 1) + 1);
        chk("r_n_sr", n_sr, 1);
        chk("r_n_dm", n_dm, 0);

        // Abort mid-header, then a normal write
        clear_trace();
        trace_on = 1'b1;
        rw_bit = 1'b0;
        cs_n   = 1'b0;
        step(1);
        repeat (5) pulse();
        chk("a_cnt5", 32'(bit_cnt), 5);
        cs_n = 1'b1;
        step(1);
        chk("a_idle", 32'(state), 0);
        chk("a_cnt0", 32'(bit_cnt), 0);
        step(1);
        chk("a_strobes", n_addr + n_sr + n_dm + n_miso, 0);
        write_body();
        cs_n = 1'b1;
        step(2);
        trace_on = 1'b0;
        chk("a_w_dm", n_dm, 1);

        // Abort on the final data edge
        clear_trace();
        trace_on = 1'b1;
        rw_bit = 1'b0;
        cs_n   = 1'b0;
        step(1);
        repeat (WIDTH) pulse();
        repeat (WIDTH - 1) pulse();
        sclk_pos = 1'b1;
        cs_n     = 1'b1;
        step(1);
        sclk_pos = 1'b0;
        chk("f_idle", 32'(state), 0);
        chk("f_cnt0", 32'(bit_cnt), 0);
        step(2);
        trace_on = 1'b0;
        chk("f_n_dm", n_dm, 0);

        // Reset during READ_SEND
        rw_bit = 1'b1;
        cs_n   = 1'b0;
        step(1);
        repeat (WIDTH) pulse();
        repeat (3) pulse();
        chk("x_cnt3", 32'(bit_cnt), 3);
        chk("x_send", 32'(state), 4);
        reset = 1'b1;
        cs_n  = 1'b1;
        step(1);
        reset = 1'b0;
        chk("x_state", 32'(state), 0);
        chk("x_miso", 32'(miso_buff), 0);
        chk("x_cnt", 32'(bit_cnt), 0);
        chk("x_busy", 32'(busy), 0);
        step(1);

        // DONE hold with extra edges
        write_body();
        clear_trace();
        trace_on = 1'b1;
        repeat (4) pulse();
        chk("d_state", 32'(state), 7);
        chk("d_cnt", 32'(bit_cnt), 0);
        chk("d_strobes", n_addr + n_sr + n_dm + n_miso, 0);
        trace_on = 1'b0;
        cs_n = 1'b1;
        step(1);
        chk("d_idle", 32'(state), 0);
        cs_n = 1'b0;
        step(1);
        chk("d_get", 32'(state), 1);
        cs_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
